// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results, resolves branches/jumps, and squashes wrong-path work.
// Optional macro MISALIGN_CHECK_EN adds memory/redirect misalignment detection and suppression.
module ex_mem_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic [1:0]  mem_size_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        jalr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] target_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic [1:0]  mem_size_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        misalign_o
);

  logic [2:0]  squash_cnt;
  logic        live;
  logic        taken;
  logic        mis_mem;
  logic        mis_pc;
  logic [31:0] next_redirect_pc;

  // An instruction is live only when no wrong-path squash is pending.
  always_comb begin
    live             = valid_i & (squash_cnt == 3'd0);
    taken            = live & ((branch_i & alu_zero_i) | jump_i);
    next_redirect_pc = jalr_i ? {alu_result_i[31:1], 1'b0} : target_i;
`ifdef MISALIGN_CHECK_EN
    mis_mem = live & (mem_read_i | mem_write_i) &
              (((mem_size_i == 2'b01) & alu_result_i[0]) |
               ((mem_size_i == 2'b10) & (alu_result_i[1:0] != 2'b00)));
    mis_pc  = taken & (next_redirect_pc[1:0] != 2'b00);
`else
    mis_mem = 1'b0;
    mis_pc  = 1'b0;
`endif
  end

  // Priority is reset, then flush, then stall; a stall drops redirect so the pulse never repeats.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o       <= 1'b0;
      addr_o        <= '0;
      wb_data_o     <= '0;
      store_data_o  <= '0;
      rd_o          <= '0;
      reg_write_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_to_reg_o  <= 1'b0;
      mem_size_o    <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      squash_cnt    <= '0;
    end else if (flush_i) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      redirect_o   <= 1'b0;
      squash_cnt   <= '0;
    end else if (stall_i) begin
      redirect_o <= 1'b0;
    end else begin
      valid_o       <= live;
      addr_o        <= alu_result_i;
      wb_data_o     <= jump_i ? pc_plus4_i : alu_result_i;
      store_data_o  <= rs2_data_i;
      rd_o          <= rd_i;
      mem_size_o    <= mem_size_i;
      reg_write_o   <= live & reg_write_i & ~mis_mem;
      mem_read_o    <= live & mem_read_i & ~mis_mem;
      mem_write_o   <= live & mem_write_i & ~mis_mem;
      mem_to_reg_o  <= live & mem_to_reg_i;
      redirect_o    <= taken & ~mis_pc;
      redirect_pc_o <= next_redirect_pc;
      // Bubbles leave the count alone so exactly SQUASH_DEPTH real instructions die.
      if (taken & ~mis_pc) begin
        squash_cnt <= 3'(SQUASH_DEPTH);
      end else if (valid_i && (squash_cnt != 3'd0)) begin
        squash_cnt <= squash_cnt - 3'd1;
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else if (flush_i) begin
      misalign_q <= 1'b0;
    end else if (!stall_i) begin
      misalign_q <= mis_mem | mis_pc;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed pipeline scenarios followed by randomized traffic.
// A behavioural model pushes expected outputs; a monitor pops and compares one entry per clock.
module tb_ex_mem_stage;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, stall_i, flush_i, valid_i, alu_zero_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_plus4_i, target_i;
  logic [4:0]  rd_i;
  logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic [1:0]  mem_size_i;
  logic        branch_i, jump_i, jalr_i;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
  logic        redirect_o, misalign_o;
  logic [31:0] addr_o, wb_data_o, store_data_o, redirect_pc_o;
  logic [4:0]  rd_o;
  logic [1:0]  mem_size_o;

  always #5 clk_i = ~clk_i;

  ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rs2_data_i(rs2_data_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .mem_size_i(mem_size_i), .branch_i(branch_i), .jump_i(jump_i), .jalr_i(jalr_i),
    .pc_plus4_i(pc_plus4_i), .target_i(target_i), .valid_o(valid_o), .addr_o(addr_o),
    .wb_data_o(wb_data_o), .store_data_o(store_data_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_size_o(mem_size_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .misalign_o(misalign_o)
  );

  typedef struct {
    bit        rst_n, stall, flush, valid, zero;
    bit [31:0] alu, rs2, pc4, tgt;
    bit [4:0]  rd;
    bit        rw, mr, mw, m2r;
    bit [1:0]  size;
    bit        br, jmp, jalr;
  } stim_t;

  typedef struct {
    bit        valid;
    bit [31:0] addr, wb_data, store_data;
    bit [4:0]  rd;
    bit        reg_write, mem_read, mem_write, mem_to_reg;
    bit [1:0]  mem_size;
    bit        redirect;
    bit [31:0] redirect_pc;
    bit        misalign;
  } out_t;

  out_t exp_q[$];
  out_t model_out;
  int   model_cnt;
  int   pass_count = 0;
  int   total_count = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: how many younger instructions still have to die is tracked as a plain integer.
  task automatic model_step(input stim_t s);
    bit        live, taken, mis_mem, mis_pc;
    bit [31:0] rpc;
    if (!s.rst_n) begin
      model_out = '{default: '0};
      model_cnt = 0;
    end else if (s.flush) begin
      model_out.valid      = 0;
      model_out.reg_write  = 0;
      model_out.mem_read   = 0;
      model_out.mem_write  = 0;
      model_out.mem_to_reg = 0;
      model_out.redirect   = 0;
      model_out.misalign   = 0;
      model_cnt = 0;
    end else if (s.stall) begin
      model_out.redirect = 0;
    end else begin
      live    = s.valid && (model_cnt == 0);
      taken   = live && ((s.br && s.zero) || s.jmp);
      rpc     = s.jalr ? s.alu - (s.alu % 2) : s.tgt;
      mis_mem = 0;
      mis_pc  = 0;
`ifdef MISALIGN_CHECK_EN
      if (live && (s.mr || s.mw))
        mis_mem = (s.size == 2'd1 && s.alu % 2 != 0) || (s.size == 2'd2 && s.alu % 4 != 0);
      mis_pc = taken && (rpc % 4 != 0);
`endif
      model_out.valid       = live;
      model_out.addr        = s.alu;
      model_out.wb_data     = s.jmp ? s.pc4 : s.alu;
      model_out.store_data  = s.rs2;
      model_out.rd          = s.rd;
      model_out.mem_size    = s.size;
      model_out.reg_write   = live && s.rw && !mis_mem;
      model_out.mem_read    = live && s.mr && !mis_mem;
      model_out.mem_write   = live && s.mw && !mis_mem;
      model_out.mem_to_reg  = live && s.m2r;
      model_out.redirect    = taken && !mis_pc;
      model_out.redirect_pc = rpc;
      model_out.misalign    = mis_mem || mis_pc;
      if (taken && !mis_pc) model_cnt = DEPTH;
      else if (s.valid && model_cnt > 0) model_cnt = model_cnt - 1;
    end
    exp_q.push_back(model_out);
  endtask

  task automatic apply_stimulus(input stim_t s);
    @(negedge clk_i);
    rst_ni = s.rst_n; stall_i = s.stall; flush_i = s.flush; valid_i = s.valid;
    alu_result_i = s.alu; alu_zero_i = s.zero; rs2_data_i = s.rs2; rd_i = s.rd;
    reg_write_i = s.rw; mem_read_i = s.mr; mem_write_i = s.mw; mem_to_reg_i = s.m2r;
    mem_size_i = s.size; branch_i = s.br; jump_i = s.jmp; jalr_i = s.jalr;
    pc_plus4_i = s.pc4; target_i = s.tgt;
    model_step(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1;
    return s;
  endfunction

  function automatic stim_t alu_op(input bit [31:0] a, input bit [4:0] r);
    stim_t s;
    s = idle();
    s.valid = 1; s.alu = a; s.rd = r; s.rw = 1; s.rs2 = a ^ 32'h5A5A_0000; s.pc4 = a + 4;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    kind;
    s = idle();
    s.rst_n = $urandom_range(0, 49) != 0;
    s.flush = $urandom_range(0, 19) == 0;
    s.stall = $urandom_range(0, 6) == 0;
    s.valid = $urandom_range(0, 9) < 7;
    s.alu   = $urandom;
    s.zero  = $urandom_range(0, 1) == 1;
    s.rs2   = $urandom;
    s.rd    = 5'($urandom);
    s.size  = 2'($urandom_range(0, 2));
    s.pc4   = $urandom & 32'hFFFF_FFFC;
    s.tgt   = $urandom;
    if ($urandom_range(0, 3) != 0) s.tgt = s.tgt & 32'hFFFF_FFFC;
    kind = int'($urandom_range(0, 7));
    case (kind)
      0, 1: s.br = 1;
      2: s.jmp = 1;
      3: begin s.jmp = 1; s.jalr = 1; s.rw = 1; end
      4: begin s.mr = 1; s.rw = 1; s.m2r = 1; end
      5: s.mw = 1;
      default: s.rw = 1;
    endcase
    return s;
  endfunction

  // Monitor: one expected entry per clock, compared just after the active edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("valid_o", 32'(valid_o), 32'(e.valid));
        check_output("addr_o", addr_o, e.addr);
        check_output("wb_data_o", wb_data_o, e.wb_data);
        check_output("store_data_o", store_data_o, e.store_data);
        check_output("rd_o", 32'(rd_o), 32'(e.rd));
        check_output("reg_write_o", 32'(reg_write_o), 32'(e.reg_write));
        check_output("mem_read_o", 32'(mem_read_o), 32'(e.mem_read));
        check_output("mem_write_o", 32'(mem_write_o), 32'(e.mem_write));
        check_output("mem_to_reg_o", 32'(mem_to_reg_o), 32'(e.mem_to_reg));
        check_output("mem_size_o", 32'(mem_size_o), 32'(e.mem_size));
        check_output("redirect_o", 32'(redirect_o), 32'(e.redirect));
        check_output("redirect_pc_o", redirect_pc_o, e.redirect_pc);
        check_output("misalign_o", 32'(misalign_o), 32'(e.misalign));
      end
    end
  end

  initial begin
    stim_t s;
    rst_ni = 0; stall_i = 0; flush_i = 0; valid_i = 0; alu_result_i = '0; alu_zero_i = 0;
    rs2_data_i = '0; rd_i = '0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0;
    mem_to_reg_i = 0; mem_size_i = '0; branch_i = 0; jump_i = 0; jalr_i = 0;
    pc_plus4_i = '0; target_i = '0;

    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.rst_n = 0;
      apply_stimulus(s);
    end
    apply_stimulus(alu_op(32'h10, 5'd5));

    s = idle(); s.valid = 1; s.br = 1; s.zero = 1; s.tgt = 32'h100;
    apply_stimulus(s);
    apply_stimulus(alu_op(32'hA0, 5'd1));
    apply_stimulus(alu_op(32'hB0, 5'd2));
    apply_stimulus(alu_op(32'hC0, 5'd3));
    apply_stimulus(idle());

    s = idle(); s.valid = 1; s.br = 1; s.zero = 0; s.tgt = 32'h200;
    apply_stimulus(s);
    apply_stimulus(alu_op(32'hD0, 5'd4));
    s = idle(); s.valid = 1; s.jmp = 1; s.jalr = 1; s.rw = 1; s.alu = 32'h203; s.pc4 = 32'h44; s.rd = 5'd1;
    apply_stimulus(s);
    apply_stimulus(alu_op(32'h11, 5'd6));
    apply_stimulus(alu_op(32'h12, 5'd7));
    apply_stimulus(alu_op(32'h13, 5'd8));

    s = idle(); s.valid = 1; s.jmp = 1; s.rw = 1; s.tgt = 32'h300; s.pc4 = 32'h84; s.rd = 5'd1;
    apply_stimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = alu_op(32'h400 + 32'(i), 5'd9);
      s.stall = 1;
      apply_stimulus(s);
    end
    apply_stimulus(alu_op(32'h500, 5'd10));
    apply_stimulus(alu_op(32'h504, 5'd11));
    apply_stimulus(alu_op(32'h508, 5'd12));

    s = idle(); s.valid = 1; s.br = 1; s.zero = 1; s.tgt = 32'h600;
    apply_stimulus(s);
    s = alu_op(32'h610, 5'd13); s.flush = 1; s.stall = 1;
    apply_stimulus(s);
    apply_stimulus(alu_op(32'h620, 5'd14));

    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.size = 2'b10; s.alu = 32'h1002; s.rd = 5'd15;
    apply_stimulus(s);
    s = idle(); s.valid = 1; s.mw = 1; s.size = 2'b01; s.alu = 32'h1002; s.rs2 = 32'hBEEF;
    apply_stimulus(s);
    apply_stimulus(idle());

    for (int i = 0; i < 800; i++) apply_stimulus(rand_stim());

    @(posedge clk_i);
    #2;
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
